// File: rtl/rx_chan_source_if.sv
// Sample-path bundle between the DDC/TX sources and rx_chan_source.
// slave = the selector itself; master = whoever drives it (rx_chain side / testbench).
interface rx_chan_source_if #(
   parameter int NUM_CHAN = 8,
   parameter int WIDTH    = 16,
   parameter int STOP_W   = 16
);
   localparam int NUM_PAIRS = NUM_CHAN / 2;

   logic                      enable;
   logic                      strobe_in;
   logic                      tx_strobe;
   logic [2*NUM_PAIRS-1:0]    mode;
   logic [NUM_CHAN*WIDTH-1:0] rx_in;
   logic [NUM_CHAN*WIDTH-1:0] tx_in;
   logic                      stop;
   logic [STOP_W-1:0]         stop_time;
   logic [NUM_CHAN*WIDTH-1:0] out;
   logic                      out_strobe;
   logic                      run_en;

   modport master (
      output enable, strobe_in, tx_strobe, mode, rx_in, tx_in, stop, stop_time,
      input  out, out_strobe, run_en
   );

   modport slave (
      input  enable, strobe_in, tx_strobe, mode, rx_in, tx_in, stop, stop_time,
      output out, out_strobe, run_en
   );
endinterface

// File: rtl/rx_chan_source.sv
// Per-I/Q-pair RX sample source select (live / loopback / counter / zero-or-PRBS) with freeze clock enable.
// Optional macro RX_SRC_PRBS_EN: mode 3 emits a 16-bit LFSR pattern (WIDTH must be 16) instead of zeros.
module rx_chan_source #(
   parameter int NUM_CHAN = 8,
   parameter int WIDTH    = 16,
   parameter int STOP_W   = 16
) (
   input logic               clock,
   input logic               reset,
   rx_chan_source_if.slave   bus
);
   localparam int NUM_PAIRS = NUM_CHAN / 2;

   logic [STOP_W-1:0]         timestop_q, timestop_d;
   logic [WIDTH-1:0]          counter_q, counter_d;
   logic [NUM_CHAN*WIDTH-1:0] loop_q, loop_d;
   logic [NUM_CHAN*WIDTH-1:0] out_q, out_d;
   logic                      out_strobe_q, out_strobe_d;
   logic                      run_en;
   logic                      fire;
`ifdef RX_SRC_PRBS_EN
   logic [15:0]               lfsr_q, lfsr_d;
`endif

   // Freeze acts as a clock enable: every state register holds while timestop is non-zero.
   assign run_en = (timestop_q == '0);
   assign fire   = run_en & bus.strobe_in & bus.enable;

   always_comb begin
      timestop_d   = timestop_q;
      counter_d    = counter_q;
      loop_d       = loop_q;
      out_d        = out_q;
      out_strobe_d = 1'b0;
`ifdef RX_SRC_PRBS_EN
      lfsr_d       = lfsr_q;
`endif

      if (timestop_q != '0)
         timestop_d = timestop_q - STOP_W'(1);
      else if (bus.stop)
         timestop_d = bus.stop_time;

      if (run_en) begin
         if (!bus.enable)
            counter_d = '0;
         else if (bus.strobe_in)
            counter_d = counter_q + WIDTH'(2);

         if (bus.tx_strobe)
            loop_d = bus.tx_in;

         if (fire) begin
            out_strobe_d = 1'b1;
            for (int unsigned k = 0; k < NUM_PAIRS; k++) begin
               case (bus.mode[2*k +: 2])
                  2'd0: out_d[2*k*WIDTH +: 2*WIDTH] = bus.rx_in[2*k*WIDTH +: 2*WIDTH];
                  2'd1: out_d[2*k*WIDTH +: 2*WIDTH] = loop_q[2*k*WIDTH +: 2*WIDTH];
                  2'd2: begin
                     out_d[2*k*WIDTH     +: WIDTH] = counter_q;
                     out_d[(2*k+1)*WIDTH +: WIDTH] = counter_q + WIDTH'(1);
                  end
                  default: begin
`ifdef RX_SRC_PRBS_EN
                     out_d[2*k*WIDTH     +: WIDTH] = WIDTH'(lfsr_q);
                     out_d[(2*k+1)*WIDTH +: WIDTH] = WIDTH'(~lfsr_q);
`else
                     out_d[2*k*WIDTH +: 2*WIDTH] = '0;
`endif
                  end
               endcase
            end
`ifdef RX_SRC_PRBS_EN
            // Fibonacci x^16+x^14+x^13+x^11+1, shifting right with feedback into the MSB.
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`endif
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         timestop_q   <= '0;
         counter_q    <= '0;
         loop_q       <= '0;
         out_q        <= '0;
         out_strobe_q <= 1'b0;
`ifdef RX_SRC_PRBS_EN
         lfsr_q       <= 16'hACE1;
`endif
      end else begin
         timestop_q   <= timestop_d;
         counter_q    <= counter_d;
         loop_q       <= loop_d;
         out_q        <= out_d;
         out_strobe_q <= out_strobe_d;
`ifdef RX_SRC_PRBS_EN
         lfsr_q       <= lfsr_d;
`endif
      end
   end

   assign bus.out        = out_q;
   assign bus.out_strobe = out_strobe_q;
   assign bus.run_en     = run_en;
endmodule

// File: tb/tb_rx_chan_source.sv
// Scoreboard bench for rx_chan_source: a per-cycle behavioural model pushes expectations, a monitor pops and compares.
module tb_rx_chan_source;
   localparam int NC = 8;
   localparam int W  = 16;
   localparam int SW = 16;

   logic clock = 1'b1;
   logic reset;
   always #5 clock = ~clock;

   rx_chan_source_if #(.NUM_CHAN(NC), .WIDTH(W), .STOP_W(SW)) bus ();
   rx_chan_source #(.NUM_CHAN(NC), .WIDTH(W), .STOP_W(SW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit           run;
      bit           strb;
      logic [127:0] out;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   running = 0;

   // stimulus for the next cycle
   bit           st_rst, st_en, st_strb, st_ts, st_stop;
   logic [15:0]  st_stime;
   logic [7:0]   st_mode;
   logic [127:0] st_rx, st_tx;

   // reference model state
   int          m_frz;
   logic [15:0] m_cnt, m_lfsr;
   logic [15:0] m_lb  [NC];
   logic [15:0] m_out [NC];
   bit          m_strb;

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      exp_t e;
      bit run, fire;
      @(negedge clock);
      reset         = st_rst;
      bus.enable    = st_en;
      bus.strobe_in = st_strb;
      bus.tx_strobe = st_ts;
      bus.mode      = st_mode;
      bus.rx_in     = st_rx;
      bus.tx_in     = st_tx;
      bus.stop      = st_stop;
      bus.stop_time = st_stime;
      if (st_rst) begin
         m_frz = 0; m_cnt = '0; m_lfsr = 16'hACE1; m_strb = 0;
         for (int c = 0; c < NC; c++) begin m_lb[c] = '0; m_out[c] = '0; end
      end else begin
         run    = (m_frz == 0);
         fire   = run && st_strb && st_en;
         m_strb = fire;
         if (fire) begin
            for (int p = 0; p < NC/2; p++) begin
               case (st_mode[2*p +: 2])
                  2'd0: begin m_out[2*p] = st_rx[32*p +: 16]; m_out[2*p+1] = st_rx[32*p+16 +: 16]; end
                  2'd1: begin m_out[2*p] = m_lb[2*p]; m_out[2*p+1] = m_lb[2*p+1]; end
                  2'd2: begin m_out[2*p] = m_cnt; m_out[2*p+1] = m_cnt + 16'd1; end
                  default: begin
`ifdef RX_SRC_PRBS_EN
                     m_out[2*p] = m_lfsr; m_out[2*p+1] = ~m_lfsr;
`else
                     m_out[2*p] = '0; m_out[2*p+1] = '0;
`endif
                  end
               endcase
            end
         end
         if (run) begin
            if (!st_en) m_cnt = '0;
            else if (st_strb) m_cnt = m_cnt + 16'd2;
            if (st_ts) for (int c = 0; c < NC; c++) m_lb[c] = st_tx[16*c +: 16];
            if (fire) m_lfsr = lfsr_next(m_lfsr);
         end
         if (m_frz != 0) m_frz = m_frz - 1;
         else if (st_stop) m_frz = int'(st_stime);
      end
      e.run  = (m_frz == 0);
      e.strb = m_strb;
      for (int c = 0; c < NC; c++) e.out[16*c +: 16] = m_out[c];
      exp_q.push_back(e);
      running = 1;
      st_strb = 0; st_ts = 0; st_stop = 0;
   endtask

   // monitor: one expectation per clock, sampled 1 time unit after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() == 0) begin
            if (running) begin
               checks++; errors++;
               $display("FAIL underflow: no expectation queued at %0t", $time);
            end
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.run_en !== e.run) begin
               errors++;
               $display("FAIL run_en at %0t: got %b want %b", $time, bus.run_en, e.run);
            end
            checks++;
            if (bus.out_strobe !== e.strb) begin
               errors++;
               $display("FAIL out_strobe at %0t: got %b want %b", $time, bus.out_strobe, e.strb);
            end
            checks++;
            if (bus.out !== e.out) begin
               errors++;
               $display("FAIL out at %0t: got %h want %h", $time, bus.out, e.out);
            end
         end
      end
   end

   initial begin
      st_rst = 1; st_en = 0; st_strb = 0; st_ts = 0; st_stop = 0; st_stime = '0;
      st_mode = '0; st_rx = '0; st_tx = '0;
      tick(); tick();
      st_rst = 0;
      tick();

      // counter mode on all pairs, three spaced strobes
      st_en = 1; st_mode = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         st_rx = rnd128(); st_strb = 1; tick(); tick();
      end

      // counter wrap on pair 1, other pairs random modes, back-to-back strobes
      while (m_cnt != 16'hFFFE) begin
         st_mode = 8'($urandom); st_mode[3:2] = 2'd2;
         st_rx = rnd128(); st_tx = rnd128(); st_ts = ($urandom_range(0, 3) == 0);
         st_strb = 1; tick();
      end
      for (int i = 0; i < 2; i++) begin st_rx = rnd128(); st_strb = 1; tick(); end

      // loopback pair 0, live on the others
      st_mode = 8'h01; st_tx = rnd128(); st_tx[31:0] = 32'hABCD_1234; st_ts = 1; tick();
      st_tx = rnd128(); st_rx = rnd128(); st_strb = 1; tick(); tick();

      // freeze of 5 together with a strobe; strobes and a stop inside the window
      st_mode = 8'hAA; st_stime = 16'd5; st_stop = 1; st_strb = 1; tick();
      for (int i = 0; i < 5; i++) begin
         st_strb = 1; st_ts = 1; st_tx = rnd128(); st_stop = (i == 2); st_stime = 16'd40; tick();
      end
      for (int i = 0; i < 3; i++) begin st_strb = 1; tick(); end

      // long freeze aborted by reset
      st_stime = 16'd100; st_stop = 1; tick();
      for (int i = 0; i < 10; i++) begin st_strb = 1; tick(); end
      st_rst = 1; tick();
      st_rst = 0; tick();

      // mode 3 on all pairs, 1000 strobes
      st_mode = 8'hFF;
      for (int i = 0; i < 1000; i++) begin st_rx = rnd128(); st_strb = 1; tick(); end

      // mixed random traffic including enable drops and short freezes
      for (int i = 0; i < 3000; i++) begin
         st_en    = ($urandom_range(0, 9) != 0);
         st_strb  = $urandom_range(0, 1);
         st_ts    = ($urandom_range(0, 2) == 0);
         st_stop  = ($urandom_range(0, 30) == 0);
         st_stime = 16'($urandom_range(0, 8));
         st_mode  = 8'($urandom);
         st_rx    = rnd128();
         st_tx    = rnd128();
         tick();
      end

      @(posedge clock);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
